// File: rtl/up_down_counter_multi.sv
// Multi-digit modulo-MODULUS up/down counter with wrap/saturate and flags.
// Define UDC_LOAD_EN to enable the parallel load path.
module up_down_counter_multi #(
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4,
  parameter int MODULUS = 10
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      count_direction,
  input  logic                      saturate,
  input  logic                      load,
  input  logic [DIGITS*DIGIT_W-1:0] load_value,
  output logic [DIGITS*DIGIT_W-1:0] digits_out,
  output logic                      terminal_count,
  output logic                      wrap_pulse,
  output logic                      at_zero
);

  localparam int W = DIGITS * DIGIT_W;
  localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MODULUS - 1);
  localparam logic [DIGIT_W-1:0] ONE_D = DIGIT_W'(1);

  logic         all_max;
  logic [W-1:0] step_next;
  logic         wrap_evt;
  logic         do_step;

  always_comb begin
    all_max = 1'b1;
    at_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits_out[i*DIGIT_W +: DIGIT_W] != MAX_D)
        all_max = 1'b0;
      if (digits_out[i*DIGIT_W +: DIGIT_W] != '0)
        at_zero = 1'b0;
    end
    terminal_count = count_direction ? all_max : at_zero;
  end

  // Ripple: each digit only moves when everything below it rolled over.
  always_comb begin
    logic                cy;
    logic [DIGIT_W-1:0]  d;
    cy        = 1'b1;
    step_next = digits_out;
    for (int i = 0; i < DIGITS; i++) begin
      d = digits_out[i*DIGIT_W +: DIGIT_W];
      if (cy) begin
        if (count_direction) begin
          if (d == MAX_D) begin
            step_next[i*DIGIT_W +: DIGIT_W] = '0;
          end else begin
            step_next[i*DIGIT_W +: DIGIT_W] = d + ONE_D;
            cy = 1'b0;
          end
        end else begin
          if (d == '0) begin
            step_next[i*DIGIT_W +: DIGIT_W] = MAX_D;
          end else begin
            step_next[i*DIGIT_W +: DIGIT_W] = d - ONE_D;
            cy = 1'b0;
          end
        end
      end
    end
  end

`ifdef UDC_LOAD_EN
  logic [W-1:0] load_clamped;

  always_comb begin
    load_clamped = load_value;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_value[i*DIGIT_W +: DIGIT_W] > MAX_D)
        load_clamped[i*DIGIT_W +: DIGIT_W] = MAX_D;
    end
  end

  assign do_step  = enable && !load
                 && !(terminal_count && saturate);
  assign wrap_evt = do_step && terminal_count;
`else
  logic unused_load;
  assign unused_load = ^{load, load_value};

  assign do_step  = enable
                 && !(terminal_count && saturate);
  assign wrap_evt = do_step && terminal_count;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      digits_out <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= wrap_evt;
`ifdef UDC_LOAD_EN
      if (load)
        digits_out <= load_clamped;
      else if (do_step)
        digits_out <= step_next;
`else
      if (do_step)
        digits_out <= step_next;
`endif
    end
  end

endmodule

// File: tb/tb_up_down_counter_multi.sv
// Directed bench for up_down_counter_multi (4 BCD digits).
// Load checks run only when UDC_LOAD_EN is defined.
module tb_up_down_counter_multi;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        count_direction;
  logic        saturate;
  logic        load;
  logic [15:0] load_value;
  logic [15:0] digits_out;
  logic        terminal_count;
  logic        wrap_pulse;
  logic        at_zero;

  int n_chk = 0;
  int n_err = 0;

  up_down_counter_multi #(
    .DIGITS(4), .DIGIT_W(4), .MODULUS(10)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .count_direction(count_direction),
    .saturate(saturate),
    .load(load),
    .load_value(load_value),
    .digits_out(digits_out),
    .terminal_count(terminal_count),
    .wrap_pulse(wrap_pulse),
    .at_zero(at_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; load = 1'b1;
    load_value = 16'h1234;
    count_direction = 1'b1; saturate = 1'b0;
    #1;
    step(1);
    check("rst_val", 32'(digits_out), 32'h0000);
    check("rst_wrap", 32'(wrap_pulse), 32'd0);
    check("rst_zero", 32'(at_zero), 32'd1);
    check("rst_tc_up", 32'(terminal_count), 32'd0);
    count_direction = 1'b0; #1;
    check("rst_tc_dn", 32'(terminal_count), 32'd1);

    // carry ripple
    reset = 1'b1; load = 1'b0; count_direction = 1'b1;
    step(10);
    check("up10", 32'(digits_out), 32'h0010);
    check("up10_zero", 32'(at_zero), 32'd0);
    step(90);
    check("up100", 32'(digits_out), 32'h0100);
    enable = 1'b0;
    step(5);
    check("hold", 32'(digits_out), 32'h0100);
    check("hold_wrap", 32'(wrap_pulse), 32'd0);

    // down end of range
    reset = 1'b0; step(1);
    reset = 1'b1; count_direction = 1'b0;
    saturate = 1'b1; enable = 1'b1;
    step(1);
    check("dn_sat", 32'(digits_out), 32'h0000);
    check("dn_sat_tc", 32'(terminal_count), 32'd1);
    check("dn_sat_wrap", 32'(wrap_pulse), 32'd0);
    saturate = 1'b0;
    step(1);
    check("dn_wrap", 32'(digits_out), 32'h9999);
    check("dn_wrap_p", 32'(wrap_pulse), 32'd1);
    check("dn_tc_9999", 32'(terminal_count), 32'd0);
    count_direction = 1'b1; #1;
    check("up_tc_9999", 32'(terminal_count), 32'd1);
    enable = 1'b0;
    step(1);
    check("wrap_1cyc", 32'(wrap_pulse), 32'd0);
    check("hold_9999", 32'(digits_out), 32'h9999);

    // up end of range
    enable = 1'b1; saturate = 1'b1;
    step(1);
    check("up_sat", 32'(digits_out), 32'h9999);
    check("up_sat_wrap", 32'(wrap_pulse), 32'd0);
    saturate = 1'b0;
    step(1);
    check("up_wrap", 32'(digits_out), 32'h0000);
    check("up_wrap_p", 32'(wrap_pulse), 32'd1);
    step(1);
    check("after_wrap", 32'(digits_out), 32'h0001);
    check("after_wrap_p", 32'(wrap_pulse), 32'd0);

    // reset during a wrap step
    count_direction = 1'b0;
    step(2);
    check("pre_mid", 32'(digits_out), 32'h9999);
    count_direction = 1'b1; reset = 1'b0;
    step(1);
    check("mid_rst_val", 32'(digits_out), 32'h0000);
    check("mid_rst_wrap", 32'(wrap_pulse), 32'd0);

    // down borrow ripple
    reset = 1'b1;
    step(1000);
    check("up1000", 32'(digits_out), 32'h1000);
    count_direction = 1'b0;
    step(1);
    check("dn_borrow", 32'(digits_out), 32'h0999);

`ifdef UDC_LOAD_EN
    enable = 1'b0; load = 1'b1;
    load_value = 16'h9999;
    step(1);
    check("ld_val", 32'(digits_out), 32'h9999);
    check("ld_nowrap", 32'(wrap_pulse), 32'd0);
    count_direction = 1'b1; #1;
    check("ld_tc", 32'(terminal_count), 32'd1);
    load = 1'b0; enable = 1'b1; saturate = 1'b0;
    step(1);
    check("ld_up_wrap", 32'(digits_out), 32'h0000);
    check("ld_up_wrap_p", 32'(wrap_pulse), 32'd1);
    load = 1'b1; saturate = 1'b1;
    step(1);
    check("reld_wrap", 32'(wrap_pulse), 32'd0);
    load = 1'b0;
    step(1);
    check("reld_sat", 32'(digits_out), 32'h9999);
    check("reld_sat_p", 32'(wrap_pulse), 32'd0);
    load = 1'b1; load_value = 16'h0A3F;
    step(1);
    check("ld_clamp", 32'(digits_out), 32'h0939);
    reset = 1'b0;
    step(1);
    check("ld_vs_rst", 32'(digits_out), 32'h0000);
`else
    enable = 1'b0; load = 1'b1;
    load_value = 16'h5555;
    step(1);
    check("noload", 32'(digits_out), 32'h0999);
    enable = 1'b1;
    step(1);
    check("noload_cnt", 32'(digits_out), 32'h0998);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
